// File: rtl/button_debouncer_n.sv
// N-channel push-button debouncer: synchroniser, stable-interval qualification, press/release pulses.
// Optional auto-repeat of press pulses while held, enabled by defining DEBOUNCER_REPEAT_EN.
module button_debouncer_n #(
    parameter int unsigned CHANNELS        = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 742500,
    parameter int unsigned REPEAT_DELAY    = 37125000,
    parameter int unsigned REPEAT_PERIOD   = 7425000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] io_in,
    output logic [CHANNELS-1:0] io_level,
    output logic [CHANNELS-1:0] io_press,
    output logic [CHANNELS-1:0] io_release,
    output logic                io_any_press
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    logic [SYNC_STAGES-1:0] sync_d [CHANNELS];
    logic [CNT_W-1:0]       cnt_q  [CHANNELS];
    logic [CNT_W-1:0]       cnt_d  [CHANNELS];

    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic                any_press_q, any_press_d;

    logic [CHANNELS-1:0] synced_c;
    logic [CHANNELS-1:0] accept_c;
    logic [CHANNELS-1:0] rep_fire_c;

    // Synchroniser shift and per-channel stable-interval qualification.
    always_comb begin
        level_d  = level_q;
        accept_c = '0;
        synced_c = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], io_in[i]};
            cnt_d[i]    = cnt_q[i];
            synced_c[i] = sync_q[i][SYNC_STAGES-1];
            if (synced_c[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                accept_c[i] = 1'b1;
                level_d[i]  = synced_c[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

`ifdef DEBOUNCER_REPEAT_EN
    localparam int unsigned      REP_MAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                              : REPEAT_PERIOD;
    localparam int unsigned      REP_W        = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_V  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PERIOD_V = REP_W'(REPEAT_PERIOD);

    logic [REP_W-1:0]    rep_cnt_q [CHANNELS];
    logic [REP_W-1:0]    rep_cnt_d [CHANNELS];
    logic [CHANNELS-1:0] rep_armed_q, rep_armed_d;

    // Repeat timer: first target is the initial delay, then the period; cleared on any edge or when idle.
    always_comb begin
        rep_fire_c  = '0;
        rep_armed_d = rep_armed_q;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            logic [REP_W-1:0] next_v;
            logic [REP_W-1:0] target_v;
            next_v       = rep_cnt_q[i] + REP_W'(1);
            target_v     = rep_armed_q[i] ? REP_PERIOD_V : REP_DELAY_V;
            rep_cnt_d[i] = next_v;
            if (accept_c[i] || !level_q[i]) begin
                rep_cnt_d[i]   = '0;
                rep_armed_d[i] = 1'b0;
            end else if (next_v == target_v) begin
                rep_fire_c[i]  = 1'b1;
                rep_cnt_d[i]   = '0;
                rep_armed_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rep_armed_q <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                rep_cnt_q[i] <= '0;
            end
        end else begin
            rep_armed_q <= rep_armed_d;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end
`else
    assign rep_fire_c = '0;

    // Repeat timing only matters in the repeat build; zero values are flagged by this scope.
    if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_repeat_cfg_zero
    end
`endif

    // Pulse generation; press and release are exclusive because a single accept picks one.
    always_comb begin
        press_d     = (accept_c & synced_c) | rep_fire_c;
        release_d   = accept_c & ~synced_c;
        any_press_d = |press_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            any_press_q <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            any_press_q <= any_press_d;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                sync_q[i] <= sync_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign io_level     = level_q;
    assign io_press     = press_q;
    assign io_release   = release_q;
    assign io_any_press = any_press_q;

endmodule

// File: tb/tb_button_debouncer_n.sv
// Directed self-checking bench for button_debouncer_n (3-channel DEBOUNCE_CYCLES=8 and 1-channel DEBOUNCE_CYCLES=1).
// Expectations adapt to the DEBOUNCER_REPEAT_EN build.
module tb_button_debouncer_n;

    localparam int unsigned CH = 3;

`ifdef DEBOUNCER_REPEAT_EN
    localparam int EXP_HOLD = 6;
    localparam int EXP_QUAL = 2;
`else
    localparam int EXP_HOLD = 0;
    localparam int EXP_QUAL = 0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [CH-1:0] in_v;
    logic [CH-1:0] level, press, rel;
    logic          any;

    logic [0:0] m_in, m_level, m_press, m_rel;
    logic       m_any;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    button_debouncer_n #(
        .CHANNELS(CH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) u_dut (
        .clock(clock), .reset(reset), .io_in(in_v),
        .io_level(level), .io_press(press), .io_release(rel), .io_any_press(any)
    );

    button_debouncer_n #(
        .CHANNELS(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) u_min (
        .clock(clock), .reset(reset), .io_in(m_in),
        .io_level(m_level), .io_press(m_press), .io_release(m_rel), .io_any_press(m_any)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_count(input int n, input int ch, output int np, output int nr, output int na);
        np = 0; nr = 0; na = 0;
        for (int j = 0; j < n; j++) begin
            tick();
            np += int'(press[ch]);
            nr += int'(rel[ch]);
            na += int'(any);
        end
    endtask

    initial begin
        int np, nr, na, tp, tr;
        int bval [6];
        int blen [6];
        bval = '{1, 0, 1, 0, 1, 0};
        blen = '{1, 2, 3, 2, 7, 2};

        reset = 1'b1; in_v = '0; m_in = '0;
        tick(); tick(); tick();
        chk("rst_level", 32'(level), 0);
        chk("rst_press", 32'(press), 0);
        chk("rst_release", 32'(rel), 0);
        chk("rst_any", 32'(any), 0);
        reset = 1'b0;
        tick();
        chk("idle_level", 32'(level), 0);

        // Clean press/hold/release on channel 0.
        in_v[0] = 1'b1;
        run_count(9, 0, np, nr, na);
        chk("clean_early_press", 32'(np), 0);
        chk("clean_early_level", 32'(level), 0);
        tick();
        chk("clean_press", 32'(press), 3'b001);
        chk("clean_level", 32'(level), 3'b001);
        chk("clean_any", 32'(any), 1);
        chk("clean_rel0", 32'(rel), 0);
        tick();
        chk("clean_press_end", 32'(press), 0);
        chk("clean_any_end", 32'(any), 0);
        run_count(48, 0, np, nr, na);
        chk("hold_presses", 32'(np), 32'(EXP_HOLD));
        chk("hold_any", 32'(na), 32'(EXP_HOLD));
        chk("hold_releases", 32'(nr), 0);
        in_v[0] = 1'b0;
        run_count(9, 0, np, nr, na);
        chk("relq_presses", 32'(np), 32'(EXP_QUAL));
        chk("relq_releases", 32'(nr), 0);
        tick();
        chk("clean_release", 32'(rel), 3'b001);
        chk("clean_rel_level", 32'(level), 0);
        chk("clean_rel_press", 32'(press), 0);
        run_count(30, 0, np, nr, na);
        chk("after_rel_presses", 32'(np), 0);
        chk("after_rel_releases", 32'(nr), 0);

        // Bounce on channel 1: 1,3,7-cycle highs must never qualify.
        tp = 0; tr = 0;
        for (int b = 0; b < 6; b++) begin
            in_v[1] = bval[b][0];
            run_count(blen[b], 1, np, nr, na);
            tp += np; tr += nr;
        end
        run_count(4, 1, np, nr, na);
        tp += np; tr += nr;
        chk("bounce_presses", 32'(tp), 0);
        chk("bounce_releases", 32'(tr), 0);
        chk("bounce_level", 32'(level), 0);
        in_v[1] = 1'b1;
        run_count(9, 1, np, nr, na);
        chk("bounce_early", 32'(np), 0);
        tick();
        chk("bounce_press", 32'(press), 3'b010);
        chk("bounce_level1", 32'(level), 3'b010);
        in_v[1] = 1'b0;
        run_count(9, 1, np, nr, na);
        chk("bounce_relq_press", 32'(np), 0);
        tick();
        chk("bounce_release", 32'(rel), 3'b010);
        chk("bounce_rel_level", 32'(level), 0);

        // Simultaneous qualification on channels 0 and 2.
        in_v = 3'b101;
        run_count(9, 0, np, nr, na);
        chk("simul_early", 32'(na), 0);
        tick();
        chk("simul_press", 32'(press), 3'b101);
        chk("simul_any", 32'(any), 1);
        chk("simul_level", 32'(level), 3'b101);
        tick();
        chk("simul_press_end", 32'(press), 0);
        chk("simul_any_end", 32'(any), 0);
        in_v = 3'b000;
        run_count(9, 2, np, nr, na);
        chk("simul_relq", 32'(np), 0);
        tick();
        chk("simul_release", 32'(rel), 3'b101);
        chk("simul_rel_level", 32'(level), 0);
        chk("simul_rel_press", 32'(press), 0);

        // Reset mid-qualification discards progress.
        in_v[0] = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        chk("midrst_level", 32'(level), 0);
        chk("midrst_press", 32'(press), 0);
        tick();
        chk("midrst_release", 32'(rel), 0);
        chk("midrst_any", 32'(any), 0);
        reset = 1'b0;
        run_count(9, 0, np, nr, na);
        chk("postrst_early", 32'(np), 0);
        chk("postrst_level", 32'(level), 0);
        tick();
        chk("postrst_press", 32'(press), 3'b001);
        chk("postrst_level1", 32'(level), 3'b001);
        in_v[0] = 1'b0;
        run_count(9, 0, np, nr, na);
        chk("postrst_relq", 32'(np), 0);
        tick();
        chk("postrst_release", 32'(rel), 3'b001);

        // Minimum debounce: one-cycle synced pulse yields press then release back to back.
        m_in = 1'b1;
        tick();
        m_in = 1'b0;
        tick();
        chk("min_pre_level", 32'(m_level), 0);
        chk("min_pre_press", 32'(m_press), 0);
        tick();
        chk("min_press", 32'(m_press), 1);
        chk("min_level", 32'(m_level), 1);
        chk("min_any", 32'(m_any), 1);
        chk("min_rel0", 32'(m_rel), 0);
        tick();
        chk("min_release", 32'(m_rel), 1);
        chk("min_rel_level", 32'(m_level), 0);
        chk("min_rel_press", 32'(m_press), 0);
        tick();
        chk("min_rel_end", 32'(m_rel), 0);
        chk("min_main_idle", 32'(level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
